// File: rtl/cam_pixel_stream.sv
// cam_pixel_stream: camera-side pixel packer.
// Collects BYTES_PER_PIXEL camera bytes per pixel while HREF (h_sync) is high and
// tags each pixel with start-of-frame / end-of-line. Pixels are queued in a small
// FIFO and leave on a valid/ready stream. Frame and line timing are tracked so that
// malformed lines and FIFO drops are reported through sticky flags.
module cam_pixel_stream #(
    parameter int BYTES_PER_PIXEL = 2,
    parameter int BYTE_ORDER      = 0,
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                         p_clk,
    input  logic                         RST,
    input  logic                         v_sync,
    input  logic                         h_sync,
    input  logic [7:0]                   i_data,
    output logic [8*BYTES_PER_PIXEL-1:0] o_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic                         o_sof,
    output logic                         o_eol,
    output logic                         o_overflow,
    output logic                         o_line_err
);
    localparam int PW   = 8 * BYTES_PER_PIXEL;
    localparam int BW   = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
    localparam int BUFW = (BYTES_PER_PIXEL > 1) ? 8 * (BYTES_PER_PIXEL - 1) : 8;
    localparam int XW   = $clog2(H_ACTIVE + 1);
    localparam int YW   = $clog2(V_ACTIVE + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);

    localparam logic [BW-1:0] LAST_BYTE = BW'(BYTES_PER_PIXEL - 1);
    localparam logic [XW-1:0] X_END     = XW'(H_ACTIVE);
    localparam logic [XW-1:0] X_LAST    = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_END     = YW'(V_ACTIVE);
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        WAIT_FRAME,
        WAIT_LINE,
        CAPTURE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            vsync_r;
    logic [XW-1:0]   x_cnt;
    logic [YW-1:0]   y_cnt;
    logic [BW-1:0]   byte_cnt;
    logic [BUFW-1:0] byte_buf;
    logic            overflow;
    logic            line_err;

    logic            frame_start;
    logic            capture;
    logic            line_end;
    logic            extra_line;

    logic [PW-1:0]   pix_word;
    logic            pix_done;
    logic            x_in_line;
    logic            push_req;
    logic            push_ok;
    logic            drop;
    logic            over_len;
    logic            err_set;

    logic [PW-1:0]   fifo_data [FIFO_DEPTH];
    logic            fifo_sof  [FIFO_DEPTH];
    logic            fifo_eol  [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   fifo_count;
    logic            fifo_pop;

    // State register; v_sync high from any state parks the machine until the next frame.
    always_ff @(posedge p_clk or negedge RST) begin
        if (!RST) begin
            state <= WAIT_FRAME;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus the per-edge control strobes; blanking beats everything, then frame start.
    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        capture     = 1'b0;
        line_end    = 1'b0;
        extra_line  = 1'b0;
        if (v_sync) begin
            state_nxt = WAIT_FRAME;
        end else if (vsync_r) begin
            frame_start = 1'b1;
            state_nxt   = WAIT_LINE;
        end else begin
            case (state)
                WAIT_LINE: begin
                    if (h_sync) begin
                        if (y_cnt < Y_END) begin
                            capture   = 1'b1;
                            state_nxt = CAPTURE;
                        end else begin
                            extra_line = 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    if (h_sync) begin
                        capture = 1'b1;
                    end else begin
                        line_end  = 1'b1;
                        state_nxt = WAIT_LINE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Assemble the finished pixel from the buffered bytes plus the byte arriving now.
    always_comb begin
        pix_word = '0;
        for (int k = 0; k < BYTES_PER_PIXEL - 1; k++) begin
            pix_word[8*((BYTE_ORDER == 0) ? k : (BYTES_PER_PIXEL - 1 - k)) +: 8] = byte_buf[8*k +: 8];
        end
        pix_word[8*((BYTE_ORDER == 0) ? (BYTES_PER_PIXEL - 1) : 0) +: 8] = i_data;
    end

    assign pix_done  = capture && (byte_cnt == LAST_BYTE);
    assign x_in_line = x_cnt < X_END;
    assign push_req  = pix_done && x_in_line;
    assign over_len  = pix_done && !x_in_line;
    assign fifo_pop  = (fifo_count != '0) && i_ready;
    assign push_ok   = push_req && ((fifo_count != FIFO_FULL) || fifo_pop);
    assign drop      = push_req && !push_ok;
    assign err_set   = extra_line || over_len ||
                       (line_end && ((byte_cnt != '0) || (x_cnt != X_END)));

    // Frame/line counters, byte collection and the sticky error flags.
    always_ff @(posedge p_clk or negedge RST) begin
        if (!RST) begin
            vsync_r  <= 1'b0;
            x_cnt    <= '0;
            y_cnt    <= '0;
            byte_cnt <= '0;
            byte_buf <= '0;
            overflow <= 1'b0;
            line_err <= 1'b0;
        end else begin
            vsync_r <= v_sync;
            if (frame_start) begin
                x_cnt    <= '0;
                y_cnt    <= '0;
                byte_cnt <= '0;
            end else if (v_sync) begin
                byte_cnt <= '0;
            end else if (line_end) begin
                y_cnt    <= y_cnt + 1'b1;
                x_cnt    <= '0;
                byte_cnt <= '0;
            end else if (capture) begin
                if (pix_done) begin
                    byte_cnt <= '0;
                    if (x_in_line) begin
                        x_cnt <= x_cnt + 1'b1;
                    end
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                    for (int k = 0; k < BYTES_PER_PIXEL - 1; k++) begin
                        if (byte_cnt == BW'(k)) begin
                            byte_buf[8*k +: 8] <= i_data;
                        end
                    end
                end
            end
            overflow <= (overflow && !frame_start) || drop;
            line_err <= (line_err && !frame_start) || err_set;
        end
    end

    // FIFO storage; contents need no reset because o_valid masks them.
    always_ff @(posedge p_clk) begin
        if (push_ok) begin
            fifo_data[wr_ptr] <= pix_word;
            fifo_sof[wr_ptr]  <= (x_cnt == '0) && (y_cnt == '0);
            fifo_eol[wr_ptr]  <= (x_cnt == X_LAST);
        end
    end

    // FIFO pointers and occupancy; a push and a pop on the same edge leave the count alone.
    always_ff @(posedge p_clk or negedge RST) begin
        if (!RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !fifo_pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (!push_ok && fifo_pop) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

    assign o_valid    = fifo_count != '0;
    assign o_data     = o_valid ? fifo_data[rd_ptr] : '0;
    assign o_sof      = o_valid && fifo_sof[rd_ptr];
    assign o_eol      = o_valid && fifo_eol[rd_ptr];
    assign o_overflow = overflow;
    assign o_line_err = line_err;

endmodule
